// File: rtl/word_serializer.sv
// word_serializer: WIDTH-bit valid/ready word to bit-serial stream, MSB or LSB first.
// Define WORD_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module word_serializer #(
    parameter int WIDTH = 16,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             bit_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef WORD_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             last, fin, accept, first_bit, next_bit;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    assign last       = state_q == SHIFT && cnt_q == '0;
`ifdef WORD_SERIALIZER_PARITY_EN
    assign fin        = state_q == PAR;
`else
    assign fin        = last;
`endif
    assign data_ready = rst & (state_q == IDLE | (bit_en & fin));
    assign accept     = data_valid & data_ready;
    assign first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    assign next_bit   = MSB_FIRST ? sreg_q[WIDTH-2] : sreg_q[1];

    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        cnt_d         = cnt_q;
        bit_out_d     = bit_out_q;
        bit_valid_d   = bit_valid_q;
        frame_start_d = frame_start_q;
`ifdef WORD_SERIALIZER_PARITY_EN
        par_d         = par_q;
`endif
        if (accept) begin
            state_d       = SHIFT;
            sreg_d        = data_in;
            cnt_d         = CW'(WIDTH - 1);
            bit_out_d     = first_bit;
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_d         = first_bit;
`endif
        end else if (bit_en && state_q == SHIFT && !last) begin
            sreg_d        = MSB_FIRST ? sreg_q << 1 : sreg_q >> 1;
            cnt_d         = cnt_q - 1'b1;
            bit_out_d     = next_bit;
            frame_start_d = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_d         = par_q ^ next_bit;
`endif
        end else if (bit_en && last) begin
`ifdef WORD_SERIALIZER_PARITY_EN
            state_d       = PAR;
            bit_out_d     = par_q;
            frame_start_d = 1'b0;
        end else if (bit_en && state_q == PAR) begin
`endif
            state_d       = IDLE;
            bit_out_d     = 1'b0;
            bit_valid_d   = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            sreg_q        <= '0;
            cnt_q         <= '0;
            bit_out_q     <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            cnt_q         <= cnt_d;
            bit_out_q     <= bit_out_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q         <= par_d;
`endif
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: MSB-first and LSB-first instances checked every cycle against a frame/index reference model.
module tb_word_serializer;
    localparam int W = 16;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int LEN = W + 1;
`else
    localparam int LEN = W;
`endif
    logic         clk = 1'b0, rst = 1'b0, data_valid = 1'b0, bit_en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         rdy_m, bo_m, bv_m, fs_m, busy_m;
    logic         rdy_l, bo_l, bv_l, fs_l, busy_l;
    int           n_cmp = 0, n_err = 0;
    logic         m_act = 1'b0, m_rdy;
    int           m_idx = 0, nbv = 0;
    logic [W-1:0] m_word = '0, col = '0;

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(rdy_m),
        .bit_en(bit_en), .bit_out(bo_m), .bit_valid(bv_m), .frame_start(fs_m), .busy(busy_m));
    word_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(rdy_l),
        .bit_en(bit_en), .bit_out(bo_l), .bit_valid(bv_l), .frame_start(fs_l), .busy(busy_l));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame bit idx of the current word in the given order; index W is the parity bit.
    function automatic logic exp_bit(input bit msb);
        if (m_idx >= W) return ^m_word;
        return msb ? m_word[W-1-m_idx] : m_word[m_idx];
    endfunction

    task automatic step(input logic r, input logic v, input logic e, input logic [W-1:0] d);
        rst = r; data_valid = v; bit_en = e; data_in = d;
        #1;
        m_rdy = r && (!m_act || (e && m_idx == LEN - 1));
        chk("ready_msb", rdy_m, m_rdy);
        chk("ready_lsb", rdy_l, m_rdy);
        @(posedge clk);
        if (!r) begin
            m_act = 1'b0; m_idx = 0;
        end else if (v && m_rdy) begin
            m_act = 1'b1; m_idx = 0; m_word = d;
        end else if (m_act && e) begin
            if (m_idx == LEN - 1) m_act = 1'b0;
            else m_idx++;
        end
        #1;
        chk("valid_msb", bv_m, m_act);
        chk("valid_lsb", bv_l, m_act);
        chk("busy_msb", busy_m, m_act);
        chk("busy_lsb", busy_l, m_act);
        chk("start_msb", fs_m, m_act && m_idx == 0);
        chk("start_lsb", fs_l, m_act && m_idx == 0);
        chk("bit_msb", bo_m, m_act ? exp_bit(1) : 1'b0);
        chk("bit_lsb", bo_l, m_act ? exp_bit(0) : 1'b0);
        if (bv_m) begin
            col = {col[W-2:0], bo_m};
            nbv++;
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        step(0, 1, 1, 16'h1234);
        step(0, 0, 0, '0);
        // single word, MSB first
        step(1, 1, 1, 16'hA5C3);
        col = {15'd0, bo_m};
        for (int i = 0; i < W - 1; i++) step(1, 0, 1, 16'hFFFF);
        chk("seq_a5c3", col, 16'hA5C3);
        for (int i = 0; i < LEN - W + 1; i++) step(1, 0, 1, '0);
        // reset mid-frame
        step(1, 1, 1, 16'hA5C3);
        for (int i = 0; i < 4; i++) step(1, 0, 1, '0);
        step(0, 0, 1, '0);
        step(1, 0, 1, '0);
        step(1, 0, 1, '0);
        // back-to-back with valid held high
        nbv = 0;
        for (int i = 0; i <= 2 * LEN + 1; i++) step(1, i <= LEN, 1, i == 0 ? 16'hFFFF : 16'h0000);
        chk("b2b_len", nbv, 2 * LEN);
        // pacing, accept from idle without bit_en
        step(1, 1, 0, 16'h8001);
        for (int i = 0; i < 2 * LEN + 4; i++) step(1, 0, i % 2 == 1, '0);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(49) != 0, $urandom_range(1), $urandom_range(9) < 7, W'($urandom));
        for (int i = 0; i < 2 * LEN; i++) step(1, 0, 1, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial stage that feeds the bit-serial shift register. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled cycle on `bit_out`, MSB first by default. Words can be issued back to back with no idle cycles. An optional even-parity bit can be appended to each frame.

## Interface
- `WIDTH`, default 16: data word width in bits; legal range 2..256.
- `MSB_FIRST`, default 1: 1 sends `data_in[WIDTH-1]` first; 0 sends `data_in[0]` first.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-low reset (0 = reset), sampled on the rising edge of `clk`.
- `data_in` input WIDTH: word to serialize; sampled on the accept edge.
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: block accepts a word this cycle.
- `bit_en` input 1: pacing strobe; the output advances one bit per cycle with `bit_en`=1.
- `bit_out` output 1: current serial bit, registered.
- `bit_valid` output 1: `bit_out` carries a frame bit.
- `frame_start` output 1: high with the first bit of each frame.
- `busy` output 1: a frame is in progress.

## Operation
- State machine:
  - IDLE: no frame in progress.
  - SHIFT: data bits are being sent.
  - PAR: parity bit is being sent; this state exists only when PARITY_EN is defined.
- Registers:
  - `sreg[WIDTH-1:0]`: holds the word being shifted.
  - `cnt`: $clog2(WIDTH+1) bits.
  - `par`: 1-bit running parity.
- Accept occurs when `data_valid` & `data_ready` are both high on a rising edge.
  - `sreg` loads `data_in` and `cnt` loads WIDTH-1.
  - The state moves to SHIFT.
  - `bit_out` takes the first bit, with `bit_valid`=1 and `frame_start`=1.
- In SHIFT with `bit_en`=1 and `cnt`≠0:
  - `sreg` shifts toward the output end, `cnt` decrements, and `bit_out` takes the next bit.
  - `frame_start` goes to 0.
- In SHIFT with `bit_en`=0: all registers hold, and `bit_valid` stays 1 (the bit is held, not dropped).
- Last bit (`cnt`=0) with `bit_en`=1:
  - Without PARITY_EN: go to IDLE, or to SHIFT again if a word is accepted on this same edge.
  - With PARITY_EN: go to PAR, and `bit_out` takes the even parity (XOR of all WIDTH data bits).
- PAR with `bit_en`=1: go to IDLE, or to SHIFT again if a word is accepted on this same edge.
- `data_ready` is combinational:
  - It is 1 when: `rst`=1 & (IDLE | (`bit_en` & final bit of the frame)).
  - "Final bit of the frame" means SHIFT with `cnt`=0 when PARITY_EN is undefined, and PAR when it is defined.
  - `data_ready` does not depend on `data_valid`.
- In IDLE: `bit_valid`=0, `bit_out`=0, `busy`=0.
- `busy` is 1 exactly when the state is not IDLE.
- `data_in` is ignored unless an accept occurs. Holding `data_valid` high with no accept has no effect.

## Timing
- Reset (`rst`=0 at an edge):
  - After the edge: state=IDLE, `sreg`=0, `cnt`=0, `par`=0, `bit_out`=0, `bit_valid`=0, `frame_start`=0, `busy`=0.
  - `data_ready`=0 for as long as `rst`=0.
- Reset mid-frame aborts the frame with no partial flush. `data_ready` returns to 1 in the first cycle with `rst`=1.
- Latency: a word accepted on edge N puts its first bit on `bit_out` in the cycle after edge N.
- Frame length with `bit_en` tied high: WIDTH cycles, or WIDTH+1 cycles with PARITY_EN.
- Back-to-back frames have zero gap: the first bit of the next word directly follows the final bit of the current frame.
- Throughput with `bit_en` tied high is one word per WIDTH (or WIDTH+1) cycles.
- `bit_en` is ignored in IDLE, and acceptance from IDLE does not require `bit_en`.
- `cnt` counts down and never wraps below 0.

## Configuration
- `WORD_SERIALIZER_PARITY_EN` defined:
  - The PAR state and `par` register are compiled in.
  - Each frame is WIDTH+1 bits, with the last bit being even parity.
- Undefined:
  - There is no PAR state.
  - Frames are exactly WIDTH bits.
  - `data_ready` asserts on the last data bit.

## Test plan
- Reset mid-frame:
  - Stimulus: WIDTH=16, `bit_en`=1, accept 0xA5C3, drive `rst`=0 at bit 5 for 1 cycle.
  - Response: next cycle `bit_valid`=0, `busy`=0; the cycle after, `data_ready`=1.
- Single word, MSB first:
  - Stimulus: WIDTH=16, `bit_en`=1, accept 0xA5C3.
  - Response: `bit_out` sequence 1010_0101_1100_0011 over 16 cycles; `frame_start` high only on the first; `busy` falls after bit 16.
- Back-to-back with `data_valid` held high:
  - Stimulus: words 0xFFFF then 0x0000.
  - Response: 32 contiguous `bit_valid` cycles; `data_ready` pulses exactly on cycle 16.
- Pacing:
  - Stimulus: `bit_en` toggled 1,0,1,0, word 0x8001, `MSB_FIRST`=0.
  - Response: each bit held 2 cycles; sequence 1,0×14,1; total 32 cycles.
- Parity (`WORD_SERIALIZER_PARITY_EN` defined):
  - Stimulus: word 0x0007, then word 0x0003.
  - Response: 17-bit frames; parity bits 1 and 0 respectively; `data_ready` asserts only during PAR.
